obs_trace_recorder: RTL and testbench

Downstream capture stage for the concolic harness. Samples the DUT's 8-bit `out` bus whenever the harness-driven observation strobe `__obs` is high while armed. Each sample is stored with a cycle timestamp in an on-chip FIFO, and the FIFO is drained through a valid/ready port so the explorer can compare traces across runs. Overflow and drop accounting are kept so truncated traces are never mistaken for complete ones.

---
 rtl/obs_trace_recorder.sv | 172 +++++++++++++++++
 tb/tb_obs_trace_recorder.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/obs_trace_recorder.sv
// obs_trace_recorder
// Capture stage for the concolic harness: samples the traced DUT output on
// every observation strobe while armed, stamps it with a cycle count since
// arm, queues it in a small FIFO and drains it over a valid/ready port.
// Overflow and drop accounting mark traces that were truncated.
//
// Optional feature: define TRACE_DEDUP_EN to store a sample only when it
// differs from the last stored value (the first capture after arm is always
// stored). Without it every qualifying strobe is stored.
module obs_trace_recorder #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16,
  parameter int TS_W   = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     arm,
  input  logic                     disarm,
  input  logic                     __obs,
  input  logic [DATA_W-1:0]        out,
  output logic                     rd_valid,
  input  logic                     rd_ready,
  output logic [DATA_W-1:0]        rd_data,
  output logic [TS_W-1:0]          rd_ts,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     overflow,
  output logic [7:0]               drop_cnt,
  output logic [1:0]               state
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CAPTURE = 2'd1,
    ST_FROZEN  = 2'd2
  } state_t;

  typedef struct packed {
    logic [TS_W-1:0]   ts;
    logic [DATA_W-1:0] data;
  } entry_t;

  state_t            state_q;
  logic [AW-1:0]     wr_ptr_q;
  logic [AW-1:0]     rd_ptr_q;
  logic [CW-1:0]     count_q;
  logic              full_q;
  logic              rd_valid_q;
  logic              overflow_q;
  logic [7:0]        drop_cnt_q;
  logic [TS_W-1:0]   ts_q;
  entry_t            mem [DEPTH];
  entry_t            head;

  logic              pop;
  logic              cap_raw;
  logic              cap;
  logic              push;
  logic              drop;
  logic [CW-1:0]     count_nxt;
  logic [TS_W-1:0]   stamp;

`ifdef TRACE_DEDUP_EN
  logic [DATA_W-1:0] last_val_q;
  logic              last_vld_q;
`endif

  // Per-cycle push/pop/drop decisions and the next occupancy.
  // NOTE: every always_comb output is assigned unconditionally up front so no
  // path can leave one unassigned and infer a latch.
  always_comb begin
    pop     = rd_valid_q && rd_ready;
    cap_raw = (state_q == ST_CAPTURE) && __obs;
`ifdef TRACE_DEDUP_EN
    cap     = cap_raw && (!last_vld_q || (out != last_val_q));
`else
    cap     = cap_raw;
`endif
    // A full FIFO still accepts a write when the head leaves in the same cycle.
    push      = cap && (!full_q || pop);
    drop      = (cap && full_q && !pop) || ((state_q == ST_FROZEN) && __obs);
    count_nxt = count_q + CW'(push) - CW'(pop);
    // The arm cycle is timestamp 0, so the first cycle after arm stamps 1.
    stamp     = ts_q + TS_W'(1);
  end

  // Control state: FSM, pointers, occupancy, accounting and timestamp.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      full_q     <= 1'b0;
      rd_valid_q <= 1'b0;
      overflow_q <= 1'b0;
      drop_cnt_q <= '0;
      ts_q       <= '0;
    end else if (arm) begin
      // Arm wins over disarm, empties the FIFO and ignores any pop or strobe.
      state_q    <= ST_CAPTURE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      full_q     <= 1'b0;
      rd_valid_q <= 1'b0;
      overflow_q <= 1'b0;
      drop_cnt_q <= '0;
      ts_q       <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q    <= count_nxt;
      full_q     <= (count_nxt == DEPTH_C);
      rd_valid_q <= (count_nxt != '0);

      if (drop) begin
        overflow_q <= 1'b1;
        if (drop_cnt_q != 8'hFF) drop_cnt_q <= drop_cnt_q + 8'd1;
      end

      if (state_q != ST_IDLE) ts_q <= stamp;

      if (disarm) begin
        state_q <= ST_IDLE;
      end else if ((state_q == ST_CAPTURE) && (count_nxt == DEPTH_C)) begin
        // Once frozen, only arm restarts capture, even after draining.
        state_q <= ST_FROZEN;
      end
    end
  end

  // FIFO storage write port.
  // NOTE: the storage array is deliberately not reset; reset and arm clear the
  // pointers and count, which makes every stale entry unreachable.
  always_ff @(posedge clk) begin
    if (push && !arm && !reset) begin
      mem[wr_ptr_q] <= '{ts: stamp, data: out};
    end
  end

`ifdef TRACE_DEDUP_EN
  // Last stored value for duplicate suppression; forgotten on arm.
  always_ff @(posedge clk) begin
    if (reset || arm) begin
      last_val_q <= '0;
      last_vld_q <= 1'b0;
    end else if (push) begin
      last_val_q <= out;
      last_vld_q <= 1'b1;
    end
  end
`endif

  // Head of queue is shown only while valid, so the port reads 0 when empty.
  assign head     = mem[rd_ptr_q];
  assign rd_valid = rd_valid_q;
  assign rd_data  = rd_valid_q ? head.data : '0;
  assign rd_ts    = rd_valid_q ? head.ts   : '0;
  assign count    = count_q;
  assign full     = full_q;
  assign overflow = overflow_q;
  assign drop_cnt = drop_cnt_q;
  assign state    = state_q;

endmodule

// File: tb/tb_obs_trace_recorder.sv
// Directed testbench for obs_trace_recorder (DEPTH=16, DATA_W=8, TS_W=16).
// Inputs change 1 time unit after a rising edge; outputs are sampled at the
// same point, i.e. after the registers have settled from that edge.
module tb_obs_trace_recorder;

  logic        clk;
  logic        reset;
  logic        arm;
  logic        disarm;
  logic        obs;
  logic [7:0]  dout;
  logic        rd_valid;
  logic        rd_ready;
  logic [7:0]  rd_data;
  logic [15:0] rd_ts;
  logic [4:0]  count;
  logic        full;
  logic        overflow;
  logic [7:0]  drop_cnt;
  logic [1:0]  state;

  int checks = 0;
  int errors = 0;

  obs_trace_recorder #(.DATA_W(8), .DEPTH(16), .TS_W(16)) dut (
    .clk      (clk),
    .reset    (reset),
    .arm      (arm),
    .disarm   (disarm),
    .__obs    (obs),
    .out      (dout),
    .rd_valid (rd_valid),
    .rd_ready (rd_ready),
    .rd_data  (rd_data),
    .rd_ts    (rd_ts),
    .count    (count),
    .full     (full),
    .overflow (overflow),
    .drop_cnt (drop_cnt),
    .state    (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Arm pulse; leaves the recorder in CAPTURE with timestamp 0.
  task automatic do_arm();
    arm = 1'b1;
    tick();
    arm = 1'b0;
  endtask

  // Push n strobes with data base+i and no reads.
  task automatic push_n(input int n, input logic [7:0] base);
    for (int i = 0; i < n; i++) begin
      obs  = 1'b1;
      dout = base + 8'(i);
      tick();
    end
    obs = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    checks++; if (state !== 2'd0) begin errors++; $display("FAIL reset_state: got %0d expected 0", state); end
    checks++; if (count !== 5'd0) begin errors++; $display("FAIL reset_count: got %0d expected 0", count); end
    checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL reset_rd_valid: got %b expected 0", rd_valid); end
    checks++; if (full !== 1'b0 || overflow !== 1'b0) begin errors++; $display("FAIL reset_flags: got full=%b ovf=%b expected 0 0", full, overflow); end
    checks++; if (drop_cnt !== 8'd0) begin errors++; $display("FAIL reset_drop_cnt: got %0d expected 0", drop_cnt); end
    checks++; if (rd_data !== 8'h00 || rd_ts !== 16'h0) begin errors++; $display("FAIL reset_head: got data=%h ts=%0d expected 00 0", rd_data, rd_ts); end
    // Strobes before any arm are ignored.
    push_n(2, 8'h99);
    checks++; if (count !== 5'd0) begin errors++; $display("FAIL idle_ignore: got count=%0d expected 0", count); end
  endtask

  task automatic test_basic();
    logic [7:0] exp_d [3];
    exp_d[0] = 8'h11; exp_d[1] = 8'h22; exp_d[2] = 8'h33;
    do_arm();
    checks++; if (state !== 2'd1) begin errors++; $display("FAIL arm_state: got %0d expected 1", state); end
    for (int i = 0; i < 3; i++) begin
      obs  = 1'b1;
      dout = exp_d[i];
      tick();
      if (i == 0) begin
        checks++; if (rd_valid !== 1'b1 || rd_data !== 8'h11 || rd_ts !== 16'd1) begin
          errors++; $display("FAIL first_latency: got v=%b d=%h ts=%0d expected 1 11 1", rd_valid, rd_data, rd_ts);
        end
      end
    end
    obs = 1'b0;
    checks++; if (count !== 5'd3) begin errors++; $display("FAIL basic_count: got %0d expected 3", count); end
    for (int i = 0; i < 3; i++) begin
      checks++; if (rd_data !== exp_d[i] || rd_ts !== 16'(i + 1)) begin
        errors++; $display("FAIL basic_entry%0d: got d=%h ts=%0d expected d=%h ts=%0d", i, rd_data, rd_ts, exp_d[i], i + 1);
      end
      rd_ready = 1'b1;
      tick();
      rd_ready = 1'b0;
    end
    checks++; if (count !== 5'd0 || rd_valid !== 1'b0) begin errors++; $display("FAIL basic_drained: got count=%0d v=%b expected 0 0", count, rd_valid); end
  endtask

  task automatic test_freeze();
    do_arm();
    push_n(20, 8'h40);
    checks++; if (state !== 2'd2) begin errors++; $display("FAIL freeze_state: got %0d expected 2", state); end
    checks++; if (full !== 1'b1 || count !== 5'd16) begin errors++; $display("FAIL freeze_full: got full=%b count=%0d expected 1 16", full, count); end
    checks++; if (drop_cnt !== 8'd4 || overflow !== 1'b1) begin errors++; $display("FAIL freeze_drops: got drop=%0d ovf=%b expected 4 1", drop_cnt, overflow); end
    for (int i = 0; i < 16; i++) begin
      checks++; if (rd_data !== 8'(8'h40 + i) || rd_ts !== 16'(i + 1)) begin
        errors++; $display("FAIL freeze_entry%0d: got d=%h ts=%0d expected d=%h ts=%0d", i, rd_data, rd_ts, 8'(8'h40 + i), i + 1);
      end
      rd_ready = 1'b1;
      tick();
      rd_ready = 1'b0;
    end
    // Draining does not resume capture; a strobe is still a drop.
    push_n(1, 8'h55);
    checks++; if (state !== 2'd2 || count !== 5'd0 || drop_cnt !== 8'd5) begin
      errors++; $display("FAIL frozen_drained: got st=%0d count=%0d drop=%0d expected 2 0 5", state, count, drop_cnt);
    end
  endtask

  task automatic test_pop_push();
    do_arm();
    push_n(15, 8'h80);
    checks++; if (count !== 5'd15 || state !== 2'd1) begin errors++; $display("FAIL pp_fill: got count=%0d st=%0d expected 15 1", count, state); end
    // Push and pop together at 15: occupancy unchanged, still capturing.
    obs = 1'b1; dout = 8'hEE; rd_ready = 1'b1;
    tick();
    rd_ready = 1'b0;
    checks++; if (count !== 5'd15 || state !== 2'd1 || drop_cnt !== 8'd0) begin
      errors++; $display("FAIL pp_same_cycle: got count=%0d st=%0d drop=%0d expected 15 1 0", count, state, drop_cnt);
    end
    dout = 8'hEF;
    tick();
    checks++; if (count !== 5'd16 || state !== 2'd2 || full !== 1'b1) begin
      errors++; $display("FAIL pp_freeze: got count=%0d st=%0d full=%b expected 16 2 1", count, state, full);
    end
    // Strobe plus pop while frozen: the strobe is a drop, the pop still happens.
    dout = 8'hF0; rd_ready = 1'b1;
    tick();
    obs = 1'b0; rd_ready = 1'b0;
    checks++; if (count !== 5'd15 || drop_cnt !== 8'd1 || overflow !== 1'b1) begin
      errors++; $display("FAIL pp_frozen_pop: got count=%0d drop=%0d ovf=%b expected 15 1 1", count, drop_cnt, overflow);
    end
    for (int i = 0; i < 15; i++) begin
      logic [7:0]  ed;
      logic [15:0] et;
      if (i < 13) begin ed = 8'(8'h82 + i); et = 16'(i + 3); end
      else if (i == 13) begin ed = 8'hEE; et = 16'd16; end
      else begin ed = 8'hEF; et = 16'd17; end
      checks++; if (rd_data !== ed || rd_ts !== et) begin
        errors++; $display("FAIL pp_entry%0d: got d=%h ts=%0d expected d=%h ts=%0d", i, rd_data, rd_ts, ed, et);
      end
      rd_ready = 1'b1;
      tick();
      rd_ready = 1'b0;
    end
  endtask

  task automatic test_backpressure();
    do_arm();
    obs = 1'b1; dout = 8'hA1; tick();
    dout = 8'hA2; tick();
    obs = 1'b0;
    for (int i = 0; i < 5; i++) begin
      dout = 8'(8'h10 * i);
      checks++; if (rd_valid !== 1'b1 || rd_data !== 8'hA1 || rd_ts !== 16'd1) begin
        errors++; $display("FAIL bp_hold%0d: got v=%b d=%h ts=%0d expected 1 a1 1", i, rd_valid, rd_data, rd_ts);
      end
      tick();
    end
    rd_ready = 1'b1;
    tick();
    rd_ready = 1'b0;
    checks++; if (count !== 5'd1 || rd_data !== 8'hA2 || rd_ts !== 16'd2) begin
      errors++; $display("FAIL bp_single_pop: got count=%0d d=%h ts=%0d expected 1 a2 2", count, rd_data, rd_ts);
    end
  endtask

  task automatic test_disarm_arm();
    // Disarm keeps contents (one entry left from backpressure test).
    disarm = 1'b1; tick(); disarm = 1'b0;
    push_n(2, 8'h77);
    checks++; if (state !== 2'd0 || count !== 5'd1 || rd_data !== 8'hA2) begin
      errors++; $display("FAIL disarm_keep: got st=%0d count=%0d d=%h expected 0 1 a2", state, count, rd_data);
    end
    // Arm and disarm together: arm wins; strobe and pop in the arm cycle ignored.
    arm = 1'b1; disarm = 1'b1; obs = 1'b1; dout = 8'h3C; rd_ready = 1'b1;
    tick();
    arm = 1'b0; disarm = 1'b0; obs = 1'b0; rd_ready = 1'b0;
    checks++; if (state !== 2'd1 || count !== 5'd0 || rd_valid !== 1'b0) begin
      errors++; $display("FAIL arm_wins: got st=%0d count=%0d v=%b expected 1 0 0", state, count, rd_valid);
    end
  endtask

  task automatic test_reset_mid();
    do_arm();
    push_n(7, 8'h60);
    checks++; if (count !== 5'd7) begin errors++; $display("FAIL mid_fill: got %0d expected 7", count); end
    reset = 1'b1; tick(); reset = 1'b0;
    checks++; if (count !== 5'd0 || rd_valid !== 1'b0 || state !== 2'd0) begin
      errors++; $display("FAIL mid_reset: got count=%0d v=%b st=%0d expected 0 0 0", count, rd_valid, state);
    end
    push_n(3, 8'h70);
    checks++; if (count !== 5'd0 || rd_valid !== 1'b0) begin
      errors++; $display("FAIL mid_ignore: got count=%0d v=%b expected 0 0", count, rd_valid);
    end
  endtask

  task automatic test_saturate();
    do_arm();
    push_n(16 + 260, 8'h00);
    checks++; if (drop_cnt !== 8'd255 || count !== 5'd16) begin
      errors++; $display("FAIL drop_saturate: got drop=%0d count=%0d expected 255 16", drop_cnt, count);
    end
  endtask

  task automatic test_dedup();
    logic [7:0]  seq [5];
    logic [7:0]  exp_d [5];
    logic [15:0] exp_t [5];
    int          n_exp;
    seq[0] = 8'h05; seq[1] = 8'h05; seq[2] = 8'h07; seq[3] = 8'h07; seq[4] = 8'h05;
`ifdef TRACE_DEDUP_EN
    n_exp = 3;
    exp_d[0] = 8'h05; exp_t[0] = 16'd1;
    exp_d[1] = 8'h07; exp_t[1] = 16'd3;
    exp_d[2] = 8'h05; exp_t[2] = 16'd5;
    exp_d[3] = 8'h00; exp_t[3] = 16'd0;
    exp_d[4] = 8'h00; exp_t[4] = 16'd0;
`else
    n_exp = 5;
    for (int i = 0; i < 5; i++) begin exp_d[i] = seq[i]; exp_t[i] = 16'(i + 1); end
`endif
    do_arm();
    for (int i = 0; i < 5; i++) begin
      obs = 1'b1; dout = seq[i]; tick();
    end
    obs = 1'b0;
    checks++; if (count !== 5'(n_exp) || drop_cnt !== 8'd0 || overflow !== 1'b0) begin
      errors++; $display("FAIL dedup_count: got count=%0d drop=%0d ovf=%b expected %0d 0 0", count, drop_cnt, overflow, n_exp);
    end
    for (int i = 0; i < n_exp; i++) begin
      checks++; if (rd_data !== exp_d[i] || rd_ts !== exp_t[i]) begin
        errors++; $display("FAIL dedup_entry%0d: got d=%h ts=%0d expected d=%h ts=%0d", i, rd_data, rd_ts, exp_d[i], exp_t[i]);
      end
      rd_ready = 1'b1; tick(); rd_ready = 1'b0;
    end
  endtask

  initial begin
    reset = 1'b1; arm = 1'b0; disarm = 1'b0; obs = 1'b0;
    dout = 8'h00; rd_ready = 1'b0;
    test_reset();
    test_basic();
    test_freeze();
    test_pop_push();
    test_backpressure();
    test_disarm_arm();
    test_reset_mid();
    test_saturate();
    test_dedup();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
